// File: rtl/pwm_pkg.sv
// Shared defaults and the feeder state type for the PWM data feeder.
package pwm_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        STARVED = 2'd2
    } feeder_state_t;
endpackage

// File: rtl/pwm_sync_fifo.sv
// Single-clock FIFO for the feeder. Provides the storage, the wrapping pointers, the occupancy count and the full/empty flags.
module pwm_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (fill == FW'(DEPTH));
    assign empty   = (fill == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset: resetting the pointers and fill is enough to discard the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer width is log2(DEPTH), so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end
endmodule

// File: rtl/pwm_data_feeder.sv
// Feeds one duty value per video line to a PWM stage. Pops the FIFO on each rising edge of hsync.
// Define PWM_FEEDER_UNDERRUN_CNT_EN to add a saturating 16-bit underrun_cnt output.
module pwm_data_feeder
    import pwm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   hsync_in,
    output logic [DATA_W-1:0]      data,
    output logic                   hsync_out,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   underrun
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]            underrun_cnt
`endif
);
    feeder_state_t     state;
    logic              hsync_d1;
    logic              rise;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    assign wr_ready = ~full;
    assign rise     = hsync_in & ~hsync_d1;

    pwm_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (rise),
        .head      (head),
        .fill      (fill),
        .full      (full),
        .empty     (empty)
    );

    // hsync_out trails hsync_d1 by one cycle, so data is updated one cycle before hsync_out rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_d1  <= 1'b0;
            hsync_out <= 1'b0;
        end else begin
            hsync_d1  <= hsync_in;
            hsync_out <= hsync_d1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data     <= '0;
            underrun <= 1'b0;
        end else if (rise) begin
            if (!empty) begin
                data  <= head;
                state <= ACTIVE;
            end else begin
                state    <= STARVED;
                underrun <= 1'b1;
            end
        end
    end

`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underrun_cnt <= '0;
        else if (rise && empty && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pwm_data_feeder.sv
// Directed self-checking bench for pwm_data_feeder (DATA_W=8, DEPTH=8).
module tb_pwm_data_feeder;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       hsync_in = 1'b0;
    logic [7:0] data;
    logic       hsync_out;
    logic [3:0] fill;
    logic       underrun;
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pwm_data_feeder #(.DATA_W(8), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .hsync_in  (hsync_in),
        .data      (data),
        .hsync_out (hsync_out),
        .fill      (fill),
        .underrun  (underrun)
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; hsync_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write(input logic [7:0] v);
        wr_valid = 1'b1; wr_data = v;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse();
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_data", 32'(data), 32'h0);
        check("rst_hsync_out", 32'(hsync_out), 32'h0);
        check("rst_fill", 32'(fill), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        check("rst_state", 32'(dut.state), 32'(IDLE));

        // Three writes, three lines: data leads hsync_out by one cycle
        write(8'd20); write(8'd40); write(8'd60);
        check("fill_3", 32'(fill), 32'd3);
        hsync_in = 1'b1; tick();
        check("l1_data", 32'(data), 32'd20);
        check("l1_hout_low", 32'(hsync_out), 32'h0);
        hsync_in = 1'b0; tick();
        check("l1_hout_high", 32'(hsync_out), 32'h1);
        check("l1_fill", 32'(fill), 32'd2);
        tick();
        hsync_in = 1'b1; tick();
        check("l2_data", 32'(data), 32'd40);
        check("l2_hout_low", 32'(hsync_out), 32'h0);
        hsync_in = 1'b0; tick();
        check("l2_hout_high", 32'(hsync_out), 32'h1);
        tick();
        write(8'd99);   // a write between lines must not disturb data
        check("hold_data", 32'(data), 32'd40);
        hsync_in = 1'b1; tick();
        check("l3_data", 32'(data), 32'd60);
        hsync_in = 1'b0; tick();
        check("l3_hout_high", 32'(hsync_out), 32'h1);
        check("l3_fill", 32'(fill), 32'd1);
        check("l3_state", 32'(dut.state), 32'(ACTIVE));

        // Starved after reset, then recovery
        do_reset();
        pulse();
        check("st_data", 32'(data), 32'h0);
        check("st_state", 32'(dut.state), 32'(STARVED));
        check("st_underrun", 32'(underrun), 32'h1);
        write(8'd5);
        pulse();
        check("rec_data", 32'(data), 32'd5);
        check("rec_state", 32'(dut.state), 32'(ACTIVE));
        check("rec_underrun", 32'(underrun), 32'h1);

        // Write coinciding with a line start on an empty FIFO
        wr_valid = 1'b1; wr_data = 8'd77; hsync_in = 1'b1;
        tick();
        wr_valid = 1'b0; hsync_in = 1'b0;
        tick();
        check("wr_rise_state", 32'(dut.state), 32'(STARVED));
        check("wr_rise_data", 32'(data), 32'd5);
        check("wr_rise_fill", 32'(fill), 32'd1);
        pulse();
        check("wr_rise_next", 32'(data), 32'd77);

        // Overfill: 9 writes into 8 entries
        do_reset();
        wr_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        check("full_ready", 32'(wr_ready), 32'h0);
        check("full_fill", 32'(fill), 32'd8);
        for (int i = 1; i <= 3; i++) begin
            pulse();
            check($sformatf("pop_%0d", i), 32'(data), 32'(i));
        end
        check("pop3_fill", 32'(fill), 32'd5);
        // Simultaneous write and pop keeps fill
        wr_valid = 1'b1; wr_data = 8'd99; hsync_in = 1'b1;
        tick();
        wr_valid = 1'b0; hsync_in = 1'b0;
        check("wrpop_fill", 32'(fill), 32'd5);
        check("wrpop_data", 32'(data), 32'd4);
        tick();
        for (int i = 5; i <= 8; i++) begin
            pulse();
            check($sformatf("pop_%0d", i), 32'(data), 32'(i));
        end
        pulse();
        check("pop_99", 32'(data), 32'd99);   // value 9 was never stored
        check("drain_fill", 32'(fill), 32'd0);

        // Long hsync pulse pops only once
        do_reset();
        write(8'd11); write(8'd22);
        hsync_in = 1'b1;
        repeat (40) tick();
        hsync_in = 1'b0;
        tick();
        check("long_fill", 32'(fill), 32'd1);
        check("long_data", 32'(data), 32'd11);

        // Asynchronous reset with fill=4, data=60
        do_reset();
        write(8'd60); write(8'd1); write(8'd2); write(8'd3); write(8'd4);
        pulse();
        check("pre_data", 32'(data), 32'd60);
        check("pre_fill", 32'(fill), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("async_data", 32'(data), 32'h0);
        check("async_fill", 32'(fill), 32'h0);
        check("async_wr_ready", 32'(wr_ready), 32'h1);
        check("async_state", 32'(dut.state), 32'(IDLE));
        check("async_underrun", 32'(underrun), 32'h0);
        tick();
        rst = 1'b0;

`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
        do_reset();
        check("cnt_rst", 32'(underrun_cnt), 32'd0);
        pulse(); pulse(); pulse();
        check("cnt_3", 32'(underrun_cnt), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
